// File: rtl/contador_pkg.sv
// Shared types and defaults for the programmable counter.
// Holds the FSM state encoding and parameter defaults.
package contador_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 6;
  localparam int DEF_RESET_VAL = 0;

endpackage

// File: rtl/contador_prog.sv
// Programmable up/down counter with one-shot or auto-reload runs.
// Ports: clk, rst_n (sync, low), load/load_val, limit, up_dn,
//   auto_reload, start, stop -> count, busy, tc, done.
module contador_prog
  import contador_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int RESET_VAL = DEF_RESET_VAL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             up_dn,
  input  logic             auto_reload,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] RV  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           st, st_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] rld, rld_n;
  logic             tc_q, tc_n;
  logic             dir, dir_n;
  logic             ar, ar_n;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] base;

  // Step wraps naturally modulo 2^WIDTH.
  assign nxt  = dir ? cnt + ONE : cnt - ONE;
  // A same-cycle load decides the start compare.
  assign base = load ? load_val : cnt;

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    rld_n = rld;
    tc_n  = 1'b0;
    dir_n = dir;
    ar_n  = ar;
    unique case (st)
      S_IDLE: begin
        if (load) begin
          cnt_n = load_val;
          rld_n = load_val;
        end
        if (start) begin
          dir_n = up_dn;
          ar_n  = auto_reload;
          if (base == limit) begin
            st_n = S_DONE;
            tc_n = 1'b1;
          end else begin
            st_n = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (load) rld_n = load_val;
        if (stop) begin
          st_n = S_IDLE;
        end else if (tc_q) begin
          // Cycle after the terminal pulse.
          if (ar) begin
            cnt_n = rld;
            tc_n  = (rld == limit);
          end else begin
            st_n = S_DONE;
          end
        end else begin
          cnt_n = nxt;
          tc_n  = (nxt == limit);
        end
      end
      S_DONE: begin
        if (load) begin
          cnt_n = load_val;
          rld_n = load_val;
          st_n  = S_IDLE;
        end else if (stop) begin
          st_n = S_IDLE;
        end
      end
      default: st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st     <= S_IDLE;
      cnt    <= RV;
      rld    <= RV;
      tc_q   <= 1'b0;
      dir    <= 1'b1;
      ar     <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st     <= st_n;
      cnt    <= cnt_n;
      rld    <= rld_n;
      tc_q   <= tc_n;
      dir    <= dir_n;
      ar     <= ar_n;
      busy_q <= (st_n == S_RUN);
      done_q <= (st_n == S_DONE);
    end
  end

  assign count = cnt;
  assign busy  = busy_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: tb/tb_contador_prog.sv
// Directed bench for contador_prog at WIDTH=6.
// Vector table plus short multi-cycle sequences.
module tb_contador_prog;

  logic       clk = 1'b0;
  logic       rst_n, load, up_dn, auto_reload;
  logic       start, stop;
  logic [5:0] load_val, limit;
  logic [5:0] count;
  logic       busy, tc, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  contador_prog #(.WIDTH(6), .RESET_VAL(0)) dut (
    .clk(clk), .rst_n(rst_n), .load(load),
    .load_val(load_val), .limit(limit),
    .up_dn(up_dn), .auto_reload(auto_reload),
    .start(start), .stop(stop), .count(count),
    .busy(busy), .tc(tc), .done(done)
  );

  typedef struct {
    logic       rn, ld;
    logic [5:0] lv, lim;
    logic       up, ar, st, sp;
    logic [5:0] ec;
    logic       eb, et, ed;
  } vec_t;

  vec_t tv[$];

  task automatic add(
    input logic rn, ld, input logic [5:0] lv, lim,
    input logic up, ar, st, sp, input logic [5:0] ec,
    input logic eb, et, ed);
    vec_t v;
    v = '{rn, ld, lv, lim, up, ar, st, sp, ec, eb, et, ed};
    tv.push_back(v);
  endtask

  task automatic drive(
    input logic rn, ld, input logic [5:0] lv, lim,
    input logic up, ar, st, sp);
    rst_n = rn; load = ld; load_val = lv; limit = lim;
    up_dn = up; auto_reload = ar; start = st; stop = sp;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
    input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] obs();
    return {count, busy, tc, done};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    // reset
    add(0,0, 0, 0,1,0,0,0,  0,0,0,0);
    // one-shot up 3..7
    add(1,1, 3, 7,1,0,0,0,  3,0,0,0);
    add(1,0, 0, 7,1,0,1,0,  3,1,0,0);
    add(1,0, 0, 7,1,0,0,0,  4,1,0,0);
    add(1,0, 0, 7,1,0,0,0,  5,1,0,0);
    add(1,0, 0, 7,1,0,0,0,  6,1,0,0);
    add(1,0, 0, 7,1,0,0,0,  7,1,1,0);
    add(1,0, 0, 7,1,0,0,0,  7,0,0,1);
    add(1,0, 0, 7,1,0,0,0,  7,0,0,1);
    add(1,0, 0, 7,1,0,1,0,  7,0,0,1);
    // wrap 62,63,0,1 (load from DONE)
    add(1,1,62, 1,1,0,0,0, 62,0,0,0);
    add(1,0, 0, 1,1,0,1,0, 62,1,0,0);
    add(1,0, 0, 1,1,0,0,0, 63,1,0,0);
    add(1,0, 0, 1,1,0,0,0,  0,1,0,0);
    add(1,0, 0, 1,1,0,0,0,  1,1,1,0);
    add(1,0, 0, 1,1,0,0,0,  1,0,0,1);
    add(1,0, 0, 1,1,0,0,1,  1,0,0,0);
    // immediate terminal, load+start
    add(1,1, 9, 9,1,0,0,0,  9,0,0,0);
    add(1,0, 0, 9,1,0,1,0,  9,0,1,1);
    add(1,0, 0, 9,1,0,0,0,  9,0,0,1);
    // stop / resume
    add(1,1, 8,40,1,0,0,0,  8,0,0,0);
    add(1,0, 0,40,1,0,1,0,  8,1,0,0);
    add(1,0, 0,40,1,0,0,0,  9,1,0,0);
    add(1,0, 0,40,1,0,0,0, 10,1,0,0);
    add(1,0, 0,40,1,0,0,1, 10,0,0,0);
    add(1,0, 0,40,1,0,0,0, 10,0,0,0);
    add(1,0, 0,40,1,0,1,0, 10,1,0,0);
    add(1,0, 0,40,1,0,0,0, 11,1,0,0);
    add(1,0, 0,40,1,0,0,0, 12,1,0,0);
    add(0,0, 0,40,1,0,0,0,  0,0,0,0);
    // auto-reload down 5..2
    add(1,1, 5, 2,0,1,0,0,  5,0,0,0);
    add(1,0, 0, 2,0,1,1,0,  5,1,0,0);
    add(1,0, 0, 2,0,1,0,0,  4,1,0,0);
    add(1,0, 0, 2,0,1,0,0,  3,1,0,0);
    add(1,0, 0, 2,0,1,0,0,  2,1,1,0);
    add(1,0, 0, 2,0,1,0,0,  5,1,0,0);
    add(1,0, 0, 2,0,1,0,0,  4,1,0,0);
    add(1,0, 0, 2,0,1,0,0,  3,1,0,0);
    add(1,0, 0, 2,0,1,0,0,  2,1,1,0);
    add(1,0, 0, 2,0,1,0,0,  5,1,0,0);
    // load in RUN only hits reload reg;
    // up_dn/auto_reload ignored mid-run
    add(1,1,30, 2,0,1,0,0,  4,1,0,0);
    add(1,0, 0, 2,1,0,0,0,  3,1,0,0);
    add(1,0, 0, 2,1,0,0,0,  2,1,1,0);
    add(1,0, 0, 2,1,0,0,0, 30,1,0,0);
    add(1,0, 0, 2,1,0,0,0, 29,1,0,0);
    add(1,0, 0, 2,1,0,0,1, 29,0,0,0);

    foreach (tv[i]) begin
      drive(tv[i].rn, tv[i].ld, tv[i].lv, tv[i].lim,
            tv[i].up, tv[i].ar, tv[i].st, tv[i].sp);
      chk($sformatf("vec%0d", i), 32'(obs()),
          32'({tv[i].ec, tv[i].eb, tv[i].et, tv[i].ed}));
    end

    // reset mid-run at count 20
    drive(0,0, 0,50,1,0,0,0);
    drive(1,1, 0,50,1,0,1,0);
    for (int i = 0; i < 20; i++)
      drive(1,0, 0,50,1,0,0,0);
    chk("run20", 32'(obs()), 32'({6'd20,3'b100}));
    drive(0,0, 0,50,1,0,0,0);
    chk("rst_mid", 32'(obs()), 32'({6'd0,3'b000}));
    drive(1,0, 0,50,1,0,0,0);
    chk("rst_idle", 32'(obs()), 32'({6'd0,3'b000}));

    // limit change mid-run, then reset in tc cycle
    drive(1,1, 0,10,1,0,1,0);
    for (int i = 0; i < 3; i++)
      drive(1,0, 0,10,1,0,0,0);
    chk("lim_pre", 32'(obs()), 32'({6'd3,3'b100}));
    drive(1,0, 0, 5,1,0,0,0);
    chk("lim_4", 32'(obs()), 32'({6'd4,3'b100}));
    drive(1,0, 0, 5,1,0,0,0);
    chk("lim_tc", 32'(obs()), 32'({6'd5,3'b110}));
    drive(0,0, 0, 5,1,0,0,0);
    chk("rst_tc", 32'(obs()), 32'({6'd0,3'b000}));

    // limit moved below count: wraps to reach it
    drive(1,1, 0,10,1,0,1,0);
    for (int i = 0; i < 3; i++)
      drive(1,0, 0,10,1,0,0,0);
    k = 0;
    while (k < 80) begin
      drive(1,0, 0, 2,1,0,0,0);
      k++;
      if (tc) break;
    end
    chk("wrap_steps", 32'(k), 32'd63);
    chk("wrap_tc", 32'(obs()), 32'({6'd2,3'b110}));
    drive(1,0, 0, 2,1,0,0,0);
    chk("wrap_done", 32'(obs()), 32'({6'd2,3'b001}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_prog.md
CONTADOR_PROG -- requirements
Module: contador_prog

Interface
REQ-001 Parameter WIDTH, default 6, counter and value width in bits; legal range 2..32.
REQ-002 Parameter RESET_VAL, default 0, value loaded into count and the reload register on reset.
REQ-003 The design SHALL use one clock and a synchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 load  in  1  write load_val into the reload register; also into count when not RUN.
REQ-007 load_val  in  WIDTH  reload/start value.
REQ-008 limit  in  WIDTH  terminal value; sampled every cycle.
REQ-009 up_dn  in  1  1=count up, 0=count down; latched on accepted start.
REQ-010 auto_reload  in  1  1=restart from reload register at terminal, 0=one-shot; latched on accepted start.
REQ-011 start  in  1  begin counting; honoured in IDLE only.
REQ-012 stop  in  1  abort counting; returns to IDLE.
REQ-013 count  out  WIDTH  current count, registered.
REQ-014 busy  out  1  high while state is RUN, registered.
REQ-015 tc  out  1  one-cycle terminal-count pulse, registered.
REQ-016 done  out  1  high while state is DONE, registered.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DONE; busy=(RUN), done=(DONE).
REQ-018 IDLE: count holds; load -> count<=load_val; start with resulting count!=limit -> RUN; start with count==limit -> DONE, tc=1 for one cycle, count unchanged.
REQ-019 load and start in the same IDLE cycle SHALL apply load_val first; the limit compare uses load_val; first step occurs on the following edge.
REQ-020 RUN: each edge, count<=count+1 (up) or count-1 (down), modulo 2^WIDTH; up wraps max->0, down wraps 0->max.
REQ-021 tc SHALL be registered high in exactly the cycle where count first displays limit.
REQ-022 RUN, edge after the tc cycle: auto_reload=1 -> count<=reload register, stay RUN; auto_reload=0 -> DONE, count holds limit.
REQ-023 Terminal detection SHALL be equality only; a count passing limit by wrap SHALL continue until equality.
REQ-024 stop in RUN SHALL take priority over stepping and reload: count holds, state -> IDLE, tc=0.
REQ-025 load in RUN SHALL update only the reload register; count is unaffected until the next reload.
REQ-026 DONE: count holds; load -> count<=load_val, IDLE; stop -> IDLE; start ignored.
REQ-027 Changing limit during RUN SHALL take effect at the next compare; no other input affects an active run.

Reset
REQ-028 rst_n=0 at an edge SHALL force count=RESET_VAL, reload register=RESET_VAL, state IDLE, busy=0, tc=0, done=0, latched up_dn=1, latched auto_reload=0.
REQ-029 Reset SHALL override all other inputs, including mid-RUN and in the tc cycle.

Structure
REQ-030 Package contador_pkg SHALL hold the FSM state type (IDLE/RUN/DONE) and the WIDTH/RESET_VAL defaults.
REQ-031 Single module; no sub-module; next-count and compare logic SHALL be inline.

Verification (WIDTH=6)
REQ-032 Reset mid-run: RUN at count 20, rst_n=0 one edge -> count=0, busy=0, tc=0, done=0, IDLE.
REQ-033 One-shot up: load 3, limit 7, up_dn=1, auto_reload=0, start -> count 3,4,5,6,7; tc only at 7; done=1 from the next cycle; count stays 7.
REQ-034 Wrap: load 62, limit 1, up -> count 62,63,0,1; tc at 1 only.
REQ-035 Auto-reload down: load 5, limit 2, up_dn=0, auto_reload=1 -> 5,4,3,2,5,4,3,2...; tc every 4th cycle; busy stays 1.
REQ-036 Stop/resume: stop at count 10 -> count holds 10, busy=0; start -> 11,12...
REQ-037 Immediate terminal: count=limit=9 in IDLE, start -> DONE next cycle, one tc pulse, count=9.
